// File: rtl/gpio_port_ioc_pkg.sv
// Shared definitions for GPIO ports with interrupt-on-change: IOC state encodings,
// default mask / direction constants and the mismatch helper.
package gpio_port_ioc_pkg;

    typedef enum logic {
        IOC_PRIME = 1'b0,
        IOC_ARMED = 1'b1
    } ioc_state_e;

    // Defaults sized for the widest port; instances slice to their own width.
    localparam logic [15:0] GPIO_IOC_MASK_DFLT   = 16'h00F0;
    localparam logic [15:0] GPIO_TRIS_RESET_DFLT = 16'hFFFF;

    function automatic logic ioc_mismatch(
        input logic [15:0] sync_v,
        input logic [15:0] ref_v,
        input logic [15:0] mask_v,
        input logic [15:0] tris_v
    );
        return |((sync_v ^ ref_v) & mask_v & tris_v);
    endfunction

endpackage

// File: rtl/gpio_port_ioc_bit_synchronizer.sv
// Multi-flop synchroniser for asynchronous inputs; reusable for any pin group
// (RA4/T0CKI, external INT, port pins).
module bit_synchronizer #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    // Shift chain: stage 0 samples the pad, each later stage copies its predecessor.
    always_comb begin
        stage_d = stage_q;
        stage_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Chain registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_port_ioc.sv
// GPIO port with TRIS/latch registers, input synchroniser and PIC-style
// interrupt-on-change flag (RBIF equivalent).
module gpio_port_ioc
    import gpio_port_ioc_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TRIS_RESET  = GPIO_TRIS_RESET_DFLT[WIDTH-1:0],
    parameter logic [WIDTH-1:0] LAT_RESET   = '0,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] IOC_MASK    = GPIO_IOC_MASK_DFLT[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] physical_in,
    output logic [WIDTH-1:0] physical_out,
    output logic [WIDTH-1:0] physical_oe,
    output logic [WIDTH-1:0] tris,
    output logic [WIDTH-1:0] port,
    input  logic [WIDTH-1:0] tris_in,
    input  logic             tris_wr_en,
    input  logic [WIDTH-1:0] port_in,
    input  logic             port_wr_en,
    input  logic             port_rd_en,
    output logic             ioc_flag,
    input  logic             ioc_flag_clr
);

    localparam int               CNT_W      = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(SYNC_STAGES);

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] lat_q,  lat_d;
    logic [WIDTH-1:0] tris_q, tris_d;
    logic [WIDTH-1:0] ref_q,  ref_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    ioc_state_e       state_q, state_d;
    logic             mismatch_s;

    bit_synchronizer #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (physical_in),
        .q   (sync_s)
    );

    // Output pins and pins outside the mask never contribute to a change.
    assign mismatch_s = ioc_mismatch(16'(sync_s), 16'(ref_q), 16'(IOC_MASK), 16'(tris_q));

    // Latch and direction register writes.
    always_comb begin
        lat_d  = lat_q;
        tris_d = tris_q;
        if (port_wr_en) begin
            lat_d = port_in;
        end else begin
            lat_d = lat_q;
        end
        if (tris_wr_en) begin
            tris_d = tris_in;
        end else begin
            tris_d = tris_q;
        end
    end

    // IOC machine: PRIME lets the synchroniser fill while ref tracks it, then ARMED.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        flag_d  = flag_q;
        case (state_q)
            IOC_PRIME: begin
                ref_d = sync_s;
                if (cnt_q == PRIME_LAST) begin
                    state_d = IOC_ARMED;
                    cnt_d   = cnt_q;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            IOC_ARMED: begin
                // A read (or RMW write) re-arms from the pre-edge sync value.
                if (port_rd_en || port_wr_en) begin
                    ref_d = sync_s;
                end else begin
                    ref_d = ref_q;
                end
                if (mismatch_s) begin
                    flag_d = 1'b1;
                end else if (ioc_flag_clr) begin
                    flag_d = 1'b0;
                end else begin
                    flag_d = flag_q;
                end
            end
            default: begin
                state_d = IOC_PRIME;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q   <= LAT_RESET;
            tris_q  <= TRIS_RESET;
            ref_q   <= '0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IOC_PRIME;
        end else begin
            lat_q   <= lat_d;
            tris_q  <= tris_d;
            ref_q   <= ref_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign physical_out = lat_q;
    assign physical_oe  = ~tris_q;
    assign tris         = tris_q;
    assign port         = (tris_q & sync_s) | (~tris_q & lat_q);
    assign ioc_flag     = flag_q;

endmodule

// File: tb/tb_gpio_port_ioc.sv
// Directed bench for gpio_port_ioc: reset, output path, IOC set/clear, masking,
// TRIS-change trigger and reset during a pin change.
module tb_gpio_port_ioc;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] physical_in;
    logic [7:0] physical_out;
    logic [7:0] physical_oe;
    logic [7:0] tris;
    logic [7:0] port;
    logic [7:0] tris_in;
    logic       tris_wr_en;
    logic [7:0] port_in;
    logic       port_wr_en;
    logic       port_rd_en;
    logic       ioc_flag;
    logic       ioc_flag_clr;

    int checks = 0;
    int errors = 0;

    gpio_port_ioc dut (
        .clk          (clk),
        .rst          (rst),
        .physical_in  (physical_in),
        .physical_out (physical_out),
        .physical_oe  (physical_oe),
        .tris         (tris),
        .port         (port),
        .tris_in      (tris_in),
        .tris_wr_en   (tris_wr_en),
        .port_in      (port_in),
        .port_wr_en   (port_wr_en),
        .port_rd_en   (port_rd_en),
        .ioc_flag     (ioc_flag),
        .ioc_flag_clr (ioc_flag_clr)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_rd;
        port_rd_en = 1'b1; step(1); port_rd_en = 1'b0;
    endtask

    task automatic pulse_clr;
        ioc_flag_clr = 1'b1; step(1); ioc_flag_clr = 1'b0;
    endtask

    task automatic write_tris(input logic [7:0] v);
        tris_in = v; tris_wr_en = 1'b1; step(1); tris_wr_en = 1'b0;
    endtask

    task automatic write_port(input logic [7:0] v);
        port_in = v; port_wr_en = 1'b1; step(1); port_wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; physical_in = 8'hFF; tris_in = 8'h00; tris_wr_en = 1'b0;
        port_in = 8'h00; port_wr_en = 1'b0; port_rd_en = 1'b0; ioc_flag_clr = 1'b0;

        // Reset
        step(2);
        check("rst_tris", tris, 8'hFF);
        check("rst_oe", physical_oe, 8'h00);
        check("rst_out", physical_out, 8'h00);
        check("rst_port", port, 8'h00);
        check("rst_flag", {7'b0, ioc_flag}, 8'h00);
        rst = 1'b0;
        step(1);
        check("sync_not_yet", port, 8'h00);
        step(1);
        check("sync_edge2", port, 8'hFF);
        step(3);
        check("prime_no_flag", {7'b0, ioc_flag}, 8'h00);

        // IOC basic: pin 5 falls
        physical_in = 8'hDF;
        step(1);
        check("ioc_port_lat1", port, 8'hFF);
        step(1);
        check("ioc_port_lat2", port, 8'hDF);
        check("ioc_flag_pre", {7'b0, ioc_flag}, 8'h00);
        step(1);
        check("ioc_flag_set", {7'b0, ioc_flag}, 8'h01);
        pulse_rd();
        check("ioc_flag_after_rd", {7'b0, ioc_flag}, 8'h01);
        pulse_clr();
        check("ioc_flag_clr", {7'b0, ioc_flag}, 8'h00);
        physical_in = 8'hFF;
        step(3);
        check("ioc_flag_reset", {7'b0, ioc_flag}, 8'h01);
        pulse_rd();
        pulse_clr();
        check("ioc_flag_clr2", {7'b0, ioc_flag}, 8'h00);

        // Masked pin 0
        physical_in = 8'hFE;
        step(4);
        check("mask_port", port, 8'hFE);
        check("mask_pin0", {7'b0, ioc_flag}, 8'h00);
        physical_in = 8'hFF;
        step(4);
        check("mask_pin0_back", {7'b0, ioc_flag}, 8'h00);

        // Pin 6 as output does not trigger
        write_tris(8'hBF);
        check("out6_oe", physical_oe, 8'h40);
        check("out6_port", port, 8'hBF);
        physical_in = 8'hBF;
        step(4);
        check("out6_flag", {7'b0, ioc_flag}, 8'h00);

        // Output -> input with sync != ref raises the flag
        write_tris(8'hFF);
        check("tris_chg_port", port, 8'hBF);
        step(1);
        check("tris_chg_flag", {7'b0, ioc_flag}, 8'h01);
        physical_in = 8'hFF;
        step(3);
        pulse_clr();
        check("tris_chg_clr", {7'b0, ioc_flag}, 8'h00);

        // Set beats clear
        physical_in = 8'hEF;
        step(3);
        check("sbc_set", {7'b0, ioc_flag}, 8'h01);
        pulse_clr();
        check("sbc_hold", {7'b0, ioc_flag}, 8'h01);
        pulse_rd();
        pulse_clr();
        check("sbc_clear", {7'b0, ioc_flag}, 8'h00);

        // Output path
        write_tris(8'h00);
        check("out_tris", tris, 8'h00);
        check("out_oe", physical_oe, 8'hFF);
        write_port(8'hA5);
        check("out_pad", physical_out, 8'hA5);
        check("out_port", port, 8'hA5);
        physical_in = 8'h5A;
        step(3);
        check("out_port_indep", port, 8'hA5);
        check("out_no_flag", {7'b0, ioc_flag}, 8'h00);

        // Reset one cycle after a pin edge
        physical_in = 8'h7F;
        step(1);
        rst = 1'b1;
        step(1);
        check("mid_rst_tris", tris, 8'hFF);
        check("mid_rst_oe", physical_oe, 8'h00);
        check("mid_rst_out", physical_out, 8'h00);
        check("mid_rst_port", port, 8'h00);
        check("mid_rst_flag", {7'b0, ioc_flag}, 8'h00);
        rst = 1'b0;
        step(2);
        check("mid_rst_sync", port, 8'h7F);
        step(4);
        check("mid_rst_no_flag", {7'b0, ioc_flag}, 8'h00);
        physical_in = 8'hFF;
        step(3);
        check("mid_rst_rearmed", {7'b0, ioc_flag}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
